// File: rtl/alu_iter.sv
// alu_iter: multi-cycle RV32I/RV32M ALU for the EX stage, start/ready/valid handshake.
// Register ops finish in one cycle. Shifts move one bit per cycle.
// Multiply uses a shift-add loop and divide uses a restoring loop; each takes WIDTH+1 cycles.
// Optional macro ALU_ITER_MEXT_EN adds the RV32M multiply/divide path.
// Without that macro, an mext op completes in one cycle with result 0.

module alu_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic             control,
   input  logic             mext,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg
);

   // state   | meaning
   // S_IDLE  | ready; single-cycle ops complete straight from here
   // S_SHIFT | iterative shift, one bit per cycle, r_cnt = bits still to go
   // S_MUL   | shift-add multiply on operand magnitudes
   // S_DIV   | restoring divide on operand magnitudes
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef ALU_ITER_MEXT_EN
      ,
      S_MUL   = 2'd2,
      S_DIV   = 2'd3
`endif
   } state_t;

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_acc, w_acc;
   logic [SHW-1:0]   r_cnt, w_cnt;
   logic             r_left, w_left;
   logic             r_fill, w_fill;
   logic             r_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero, r_neg;
   logic             w_done;
   logic [WIDTH-1:0] w_fin;
   logic [WIDTH-1:0] w_base;
   logic [SHW-1:0]   w_shamt;

   assign w_shamt = b[SHW-1:0];

`ifdef ALU_ITER_MEXT_EN
   logic [WIDTH-1:0]   r_q, w_q;
   logic [WIDTH-1:0]   r_m, w_m;
   logic [WIDTH-1:0]   r_a, w_a;
   logic [1:0]         r_op, w_op;
   logic               r_sgn_q, w_sgn_q;
   logic               r_sgn_r, w_sgn_r;
   logic               r_dz, w_dz;
   logic               w_sa, w_sb;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_prod, w_prods;
   logic [WIDTH:0]     w_rsh, w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_mag, w_quo_mag, w_quo, w_rem;

   // Signedness per op: mulh both signed, mulhsu only a; div/rem signed when operation[0]=0.
   assign w_sa    = a[WIDTH-1] & (operation[2] ? ~operation[0]
                                  : (operation[1:0] == 2'b01 || operation[1:0] == 2'b10));
   assign w_sb    = b[WIDTH-1] & (operation[2] ? ~operation[0] : (operation[1:0] == 2'b01));
   assign w_mag_a = w_sa ? -a : a;
   assign w_mag_b = w_sb ? -b : b;

   // The multiplier magnitude is held in r_q and shifts right into the low half of the product.
   assign w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
   assign w_prod  = {w_madd[WIDTH:1], w_madd[0], r_q[WIDTH-1:1]};
   assign w_prods = r_sgn_q ? -w_prod : w_prod;

   // Restoring step: the remainder picks up the next dividend bit, and the step keeps the difference if it did not borrow.
   assign w_rsh     = {r_acc, r_q[WIDTH-1]};
   assign w_diff    = w_rsh - {1'b0, r_m};
   assign w_ge      = ~w_diff[WIDTH];
   assign w_rem_mag = w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
   assign w_quo_mag = {r_q[WIDTH-2:0], w_ge};
   // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) with no negation is MIN.
   assign w_quo     = r_dz ? '1  : (r_sgn_q ? -w_quo_mag : w_quo_mag);
   assign w_rem     = r_dz ? r_a : (r_sgn_r ? -w_rem_mag : w_rem_mag);
`endif

   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic left,
                                               input logic fill);
      shift1 = left ? {v[WIDTH-2:0], 1'b0} : {fill, v[WIDTH-1:1]};
   endfunction

   // Single-cycle register-op results.
   always_comb begin
      w_base = '0;
      case (operation)
         3'b000:  w_base = control ? a - b : a + b;
         3'b010:  w_base = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         3'b011:  w_base = {{(WIDTH-1){1'b0}}, a < b};
         3'b100:  w_base = a ^ b;
         3'b110:  w_base = a | b;
         3'b111:  w_base = a & b;
         default: w_base = '0;
      endcase
   end

   // Next-state and datapath update; w_done marks the completing cycle.
   always_comb begin
      w_state = r_state;
      w_acc   = r_acc;
      w_cnt   = r_cnt;
      w_left  = r_left;
      w_fill  = r_fill;
      w_done  = 1'b0;
      w_fin   = '0;
`ifdef ALU_ITER_MEXT_EN
      w_q     = r_q;
      w_m     = r_m;
      w_a     = r_a;
      w_op    = r_op;
      w_sgn_q = r_sgn_q;
      w_sgn_r = r_sgn_r;
      w_dz    = r_dz;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (mext) begin
`ifdef ALU_ITER_MEXT_EN
                  w_acc   = '0;
                  w_q     = w_mag_a;
                  w_m     = w_mag_b;
                  w_a     = a;
                  w_op    = operation[1:0];
                  w_sgn_q = w_sa ^ w_sb;
                  w_sgn_r = operation[2] & w_sa;
                  w_dz    = (b == '0);
                  w_cnt   = SHW'(WIDTH - 1);
                  w_state = operation[2] ? S_DIV : S_MUL;
`else
                  w_done  = 1'b1;
                  w_fin   = '0;
`endif
               end else if (operation[1:0] == 2'b01) begin
                  // The first shift step happens at acceptance, so valid lands shamt cycles later.
                  w_left = ~operation[2];
                  w_fill = control & operation[2] & a[WIDTH-1];
                  w_acc  = shift1(a, ~operation[2], control & operation[2] & a[WIDTH-1]);
                  if (w_shamt == '0) begin
                     w_done = 1'b1;
                     w_fin  = a;
                  end else if (w_shamt == SHW'(1)) begin
                     w_done = 1'b1;
                     w_fin  = w_acc;
                  end else begin
                     w_cnt   = w_shamt - SHW'(1);
                     w_state = S_SHIFT;
                  end
               end else begin
                  w_done = 1'b1;
                  w_fin  = w_base;
               end
            end
         end
         S_SHIFT: begin
            w_acc = shift1(r_acc, r_left, r_fill);
            if (r_cnt == SHW'(1)) begin
               w_done = 1'b1;
               w_fin  = w_acc;
            end else begin
               w_cnt = r_cnt - SHW'(1);
            end
         end
`ifdef ALU_ITER_MEXT_EN
         S_MUL: begin
            w_acc = w_madd[WIDTH:1];
            w_q   = {w_madd[0], r_q[WIDTH-1:1]};
            if (r_cnt == '0) begin
               w_done = 1'b1;
               w_fin  = (r_op == 2'b00) ? w_prods[WIDTH-1:0] : w_prods[2*WIDTH-1:WIDTH];
            end else begin
               w_cnt = r_cnt - SHW'(1);
            end
         end
         S_DIV: begin
            w_acc = w_rem_mag;
            w_q   = w_quo_mag;
            if (r_cnt == '0) begin
               w_done = 1'b1;
               w_fin  = r_op[1] ? w_rem : w_quo;
            end else begin
               w_cnt = r_cnt - SHW'(1);
            end
         end
`endif
         default: w_state = S_IDLE;
      endcase
      if (w_done) w_state = S_IDLE;
   end

   // State, datapath and result registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_left   <= 1'b0;
         r_fill   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
`ifdef ALU_ITER_MEXT_EN
         r_q      <= '0;
         r_m      <= '0;
         r_a      <= '0;
         r_op     <= '0;
         r_sgn_q  <= 1'b0;
         r_sgn_r  <= 1'b0;
         r_dz     <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_acc   <= w_acc;
         r_cnt   <= w_cnt;
         r_left  <= w_left;
         r_fill  <= w_fill;
         r_valid <= w_done;
         if (w_done) begin
            r_result <= w_fin;
            r_zero   <= (w_fin == '0);
            r_neg    <= w_fin[WIDTH-1];
         end
`ifdef ALU_ITER_MEXT_EN
         r_q     <= w_q;
         r_m     <= w_m;
         r_a     <= w_a;
         r_op    <= w_op;
         r_sgn_q <= w_sgn_q;
         r_sgn_r <= w_sgn_r;
         r_dz    <= w_dz;
`endif
      end
   end

   assign ready  = (r_state == S_IDLE);
   assign valid  = r_valid;
   assign result = r_result;
   assign zero   = r_zero;
   assign neg    = r_neg;

endmodule
